sram_responder: RTL

Synthesizable cycle-based model of the external 1M x 16 asynchronous SRAM (IS61WV102416 family) that sits on the pin side of the SRAM controller. It decodes CE_N/OE_N/WE_N/LB_N/UB_N, stores data with byte-lane masking and returns read data on the shared tristate bus after a programmable latency. It is used for FPGA emulation and RTL regression in place of the physical device, and reports protocol status for verification.

---
 rtl/sram_responder_if.sv | 24 ++
 rtl/sram_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - control and status pins of the emulated 1M x 16 async SRAM
interface sram_responder_if;
    logic        CE_N;
    logic        OE_N;
    logic        WE_N;
    logic        LB_N;
    logic        UB_N;
    logic [19:0] addr;
    logic        rd_valid;
    logic        violation;
    logic [15:0] write_count;

    // Controller side: drives the SRAM pins, observes the status outputs
    modport master (
        output CE_N, OE_N, WE_N, LB_N, UB_N, addr,
        input  rd_valid, violation, write_count
    );

    // Responder side: the SRAM model itself
    modport slave (
        input  CE_N, OE_N, WE_N, LB_N, UB_N, addr,
        output rd_valid, violation, write_count
    );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - cycle-based model of an external async 16-bit SRAM with byte lanes
module sram_responder #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_responder_if.slave  bus,
    inout  wire  [15:0]      data
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] LAT     = 4'(READ_LATENCY);
    localparam logic [3:0] LAT_M1  = 4'(READ_LATENCY - 1);

    logic [15:0]       mem [0:DEPTH-1];

    state_t            state;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [15:0]       wdata;
    logic              wlb_n;
    logic              wub_n;
    logic [3:0]        cnt;
    logic [15:0]       dout;
    logic              rd_valid;
    logic              violation;
    logic [15:0]       write_count;

    logic              wr;
    logic              rd;
    logic              drive;
    logic              commit;
    logic [ADDR_W-1:0] cur_addr;

    // Only the low ADDR_W address bits index the array; higher addresses alias onto it
    assign cur_addr = bus.addr[ADDR_W-1:0];
    if (ADDR_W < 20) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.addr[19:ADDR_W];
    end

    assign wr    = !bus.CE_N && !bus.WE_N;
    assign rd    = !bus.CE_N && !bus.OE_N && bus.WE_N;
    assign drive = !bus.CE_N && !bus.OE_N && bus.WE_N;

    // Bus drive follows the pins directly so it releases in the same cycle WE_N falls
    assign data[7:0]  = (drive && !bus.LB_N) ? dout[7:0]  : 8'hzz;
    assign data[15:8] = (drive && !bus.UB_N) ? dout[15:8] : 8'hzz;

    // A pending write lands once WR drops; a write with both lanes off is a no-op
    assign commit = rst && (state == WRITE) && !wr && (!wlb_n || !wub_n);

    assign bus.rd_valid    = rd_valid;
    assign bus.violation   = violation;
    assign bus.write_count = write_count;

    // Memory array update with per-lane masking; contents survive reset
    always_ff @(posedge clk) begin
        if (commit) begin
            if (!wlb_n) mem[waddr][7:0]  <= wdata[7:0];
            if (!wub_n) mem[waddr][15:8] <= wdata[15:8];
        end
    end

    // Pin-protocol state machine: write capture, read latency and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            waddr       <= '0;
            raddr       <= '0;
            wdata       <= '0;
            wlb_n       <= 1'b1;
            wub_n       <= 1'b1;
            cnt         <= '0;
            dout        <= '0;
            rd_valid    <= 1'b0;
            violation   <= 1'b0;
            write_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr) begin
                        state <= WRITE;
                        waddr <= cur_addr;
                        wdata <= data;
                        wlb_n <= bus.LB_N;
                        wub_n <= bus.UB_N;
                    end else if (rd) begin
                        state <= READ;
                        raddr <= cur_addr;
                        cnt   <= '0;
                    end
                end
                WRITE: begin
                    if (wr) begin
                        // The commit always targets the address captured at write start
                        if (cur_addr != waddr && (!bus.LB_N || !bus.UB_N))
                            violation <= 1'b1;
                        if (bus.LB_N != wlb_n || bus.UB_N != wub_n)
                            violation <= 1'b1;
                        wdata <= data;
                        wlb_n <= bus.LB_N;
                        wub_n <= bus.UB_N;
                    end else begin
                        if (!wlb_n || !wub_n)
                            write_count <= write_count + 16'd1;
                        if (rd) begin
                            state <= READ;
                            raddr <= cur_addr;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (wr) begin
                        state    <= WRITE;
                        waddr    <= cur_addr;
                        wdata    <= data;
                        wlb_n    <= bus.LB_N;
                        wub_n    <= bus.UB_N;
                        rd_valid <= 1'b0;
                    end else if (!rd) begin
                        state    <= IDLE;
                        rd_valid <= 1'b0;
                    end else if (cur_addr != raddr) begin
                        // New address restarts the latency; stale dout stays on the bus
                        raddr    <= cur_addr;
                        cnt      <= '0;
                        rd_valid <= 1'b0;
                    end else if (cnt < LAT) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == LAT_M1) begin
                            dout     <= mem[raddr];
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        dout <= mem[raddr];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
